fifo_rd_ctrl: RTL and testbench

Read-side pointer and status controller for the team's dual-clock FIFO. It is the counterpart of the write-pointer controller. It synchronizes the write domain's Gray pointer into the read clock domain and maintains the binary and Gray read pointers. It generates empty, almost-empty, fill level, read-valid and underflow status, and drives the read address of the shared dual-port RAM (1-cycle synchronous read).

---
 rtl/fifo_rd_ctrl.sv | 98 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and status controller for the dual-clock FIFO.
// Synchronizes the write Gray pointer and produces the read pointers, status flags and the RAM read address.
module fifo_rd_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AE_THRESH   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   wr_gray_async,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   rd_bin,
   output logic [ADDR_WIDTH:0]   rd_gray,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  rd_valid,
   output logic                  underflow
);

   localparam int unsigned PW = ADDR_WIDTH + 1;

   logic [SYNC_STAGES-1:0][PW-1:0] r_sync;
   logic [PW-1:0] r_rd_bin;
   logic [PW-1:0] r_rd_gray;
   logic [PW-1:0] r_rd_level;
   logic          r_empty;
   logic          r_almost_empty;
   logic          r_rd_valid;
   logic          r_underflow;

   logic [PW-1:0] w_wr_gray_sync;
   logic [PW-1:0] w_wr_bin_sync;
   logic [PW-1:0] w_rd_bin_next;
   logic [PW-1:0] w_rd_gray_next;
   logic [PW-1:0] w_level_next;
   logic          w_rd_fire;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = int'(PW) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Plain flop chain into the read domain; stage 0 is the only flop seeing the async input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= wr_gray_async;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_wr_gray_sync = r_sync[SYNC_STAGES-1];
   assign w_wr_bin_sync  = gray2bin(w_wr_gray_sync);
   assign w_rd_fire      = rd_en & ~r_empty;
   assign w_rd_bin_next  = r_rd_bin + PW'(w_rd_fire);
   assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
   assign w_level_next   = w_wr_bin_sync - w_rd_bin_next;

   // Pointer and status registers; status uses the lagging synced write pointer so it is never optimistic
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_bin       <= '0;
         r_rd_gray      <= '0;
         r_rd_level     <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_rd_valid     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_rd_bin       <= w_rd_bin_next;
         r_rd_gray      <= w_rd_gray_next;
         r_rd_level     <= w_level_next;
         r_empty        <= (w_rd_gray_next == w_wr_gray_sync);
         r_almost_empty <= (w_level_next <= PW'(AE_THRESH));
         r_rd_valid     <= w_rd_fire;
         r_underflow    <= rd_en & r_empty;
      end
   end

   assign rd_addr      = r_rd_bin[ADDR_WIDTH-1:0];
   assign rd_bin       = r_rd_bin;
   assign rd_gray      = r_rd_gray;
   assign empty        = r_empty;
   assign almost_empty = r_almost_empty;
   assign rd_level     = r_rd_level;
   assign rd_valid     = r_rd_valid;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl against a word-count reference model
// (unbounded read/write counts, write history delayed by the synchronizer depth).
module tb_fifo_rd_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned S  = 2;
   localparam int unsigned AE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rd_en = 1'b0;
   logic [PW-1:0] wr_gray_async = '0;
   logic [AW-1:0] rd_addr;
   logic [PW-1:0] rd_bin;
   logic [PW-1:0] rd_gray;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rd_level;
   logic          rd_valid;
   logic          underflow;

   fifo_rd_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(S), .AE_THRESH(AE)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_gray_async(wr_gray_async),
      .rd_addr(rd_addr), .rd_bin(rd_bin), .rd_gray(rd_gray), .empty(empty),
      .almost_empty(almost_empty), .rd_level(rd_level), .rd_valid(rd_valid),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: total words written/read and the write counts seen at past edges
   int wr_cnt = 0;
   int m_rd   = 0;
   int m_level = 0;
   bit m_valid = 0;
   bit m_uf    = 0;
   int hist[$];
   logic [PW-1:0] prev_gray = '0;
   int valid_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] to_gray(input int n);
      logic [PW-1:0] b;
      b = PW'(n % (1 << PW));
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      hist = {};
      for (int i = 0; i <= int'(S); i++) hist.push_back(0);
      m_rd = 0; m_level = 0; m_valid = 0; m_uf = 0;
      prev_gray = '0;
   endtask

   task automatic model_step(input bit rd);
      bit fire;
      fire    = rd && (m_level != 0);
      m_uf    = rd && (m_level == 0);
      m_valid = fire;
      if (fire) m_rd++;
      hist.push_front(wr_cnt);
      m_level = hist[S] - m_rd;
      void'(hist.pop_back());
   endtask

   task automatic compare_all();
      logic [PW-1:0] eb;
      eb = PW'(m_rd % (1 << PW));
      check_eq("rd_bin", 32'(rd_bin), 32'(eb));
      check_eq("rd_addr", 32'(rd_addr), 32'(eb[AW-1:0]));
      check_eq("rd_gray", 32'(rd_gray), 32'(eb ^ (eb >> 1)));
      check_eq("gray_one_bit", 32'($countones(rd_gray ^ prev_gray) <= 1), 32'd1);
      check_eq("rd_level", 32'(rd_level), 32'(m_level));
      check_eq("empty", 32'(empty), 32'(m_level == 0));
      check_eq("almost_empty", 32'(almost_empty), 32'(m_level <= int'(AE)));
      check_eq("rd_valid", 32'(rd_valid), 32'(m_valid));
      check_eq("underflow", 32'(underflow), 32'(m_uf));
      check_eq("level_in_range", 32'(m_level >= 0 && m_level <= (1 << AW)), 32'd1);
      prev_gray = rd_gray;
      if (rd_valid) valid_cnt++;
   endtask

   // One read-clock cycle, entered and left at a negedge
   task automatic cycle(input bit rd, input bit wr);
      rd_en = rd;
      if (wr) wr_cnt++;
      wr_gray_async = to_gray(wr_cnt);
      @(posedge clk);
      model_step(rd);
      #1 compare_all();
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_rd_bin"}, 32'(rd_bin), 32'd0);
      check_eq({pfx, "_rd_gray"}, 32'(rd_gray), 32'd0);
      check_eq({pfx, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check_eq({pfx, "_empty"}, 32'(empty), 32'd1);
      check_eq({pfx, "_almost_empty"}, 32'(almost_empty), 32'd1);
      check_eq({pfx, "_rd_level"}, 32'(rd_level), 32'd0);
      check_eq({pfx, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check_eq({pfx, "_underflow"}, 32'(underflow), 32'd0);
   endtask

   // Asynchronous assertion mid-cycle with rd_en high; release at a negedge
   task automatic mid_reset();
      rd_en = 1'b1;
      #2 rst = 1'b1;
      #1 check_reset_vals("async_rst");
      wr_cnt = 0;
      wr_gray_async = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("init");
      rst = 1'b0;

      // First read after release underflows without moving the pointer
      cycle(1, 0);
      check_eq("post_rst_underflow", 32'(underflow), 32'd1);
      check_eq("post_rst_rd_bin", 32'(rd_bin), 32'd0);

      // Fill visibility: one word shows up two edges after capture
      cycle(0, 1);
      check_eq("fill_e0_empty", 32'(empty), 32'd1);
      cycle(0, 0);
      cycle(0, 0);
      check_eq("fill_e2_level", 32'(rd_level), 32'd1);
      check_eq("fill_e2_empty", 32'(empty), 32'd0);
      check_eq("fill_e2_ae", 32'(almost_empty), 32'd1);

      // Drain five words with rd_en held for seven cycles
      wr_cnt = 4;
      cycle(0, 1);
      cycle(0, 0);
      cycle(0, 0);
      valid_cnt = 0;
      for (int i = 0; i < 7; i++) cycle(1, 0);
      check_eq("drain_valid_cnt", 32'(valid_cnt), 32'd5);
      check_eq("drain_rd_bin", 32'(rd_bin), 32'd5);
      check_eq("drain_empty", 32'(empty), 32'd1);

      // Full level: sixteen words visible
      wr_cnt = 20;
      cycle(0, 1);
      cycle(0, 0);
      cycle(0, 0);
      check_eq("full_level", 32'(rd_level), 32'd16);
      check_eq("full_ae", 32'(almost_empty), 32'd0);
      for (int i = 0; i < 14; i++) cycle(1, 0);
      check_eq("after14_level", 32'(rd_level), 32'd2);
      check_eq("after14_ae", 32'(almost_empty), 32'd1);

      // Read and visible write in the same cycle keep the level at three
      cycle(0, 1);
      cycle(0, 0);
      cycle(0, 0);
      cycle(0, 1);
      cycle(0, 0);
      cycle(1, 0);
      check_eq("simul_level", 32'(rd_level), 32'd3);
      check_eq("simul_empty", 32'(empty), 32'd0);
      check_eq("simul_valid", 32'(rd_valid), 32'd1);

      // Random traffic, long enough to wrap the pointer several times
      for (int i = 0; i < 1200; i++) begin
         bit rd, wr;
         rd = ($urandom % 10) < 6;
         wr = (($urandom % 10) < 5) && (wr_cnt + 1 - m_rd <= (1 << AW));
         cycle(rd, wr);
      end
      check_eq("wrapped", 32'(m_rd > 40), 32'd1);

      // Mid-stream reset with a read in flight
      while (m_level == 0) cycle(0, 1);
      cycle(1, 0);
      mid_reset();
      cycle(1, 0);
      check_eq("mid_rst_underflow", 32'(underflow), 32'd1);
      check_eq("mid_rst_valid", 32'(rd_valid), 32'd0);
      check_eq("mid_rst_rd_bin", 32'(rd_bin), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
